cdc_event_sender: RTL and testbench

Source-domain transmitter for the level-based clock-domain-crossing path in the video subsystem. Converts single-cycle events with a payload into a four-phase req/ack handshake: it raises a level request and holds the data stable until the destination domain returns an acknowledge. The destination side samples `req_out` through its multi-stage synchronizer. The acknowledge comes back asynchronously and is synchronized inside this block. A one-entry pending buffer absorbs an event arriving during a transfer; further events are dropped and counted.

---
 rtl/cdc_event_sender.sv | 139 +++++++++++++
 tb/tb_cdc_event_sender.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_event_sender.sv
// cdc_event_sender: source-domain half of a four-phase req/ack crossing.
// Single-cycle events with a payload become a level request. The payload is
// held stable until the destination acknowledges. One event that arrives
// during a transfer waits in a one-entry buffer. Any further event is dropped
// and counted in a saturating counter.
module cdc_event_sender #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 4
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          event_in,
  input  logic [DW-1:0] event_data,
  input  logic          ack_in,
  input  logic          clr_drop,
  output logic          req_out,
  output logic [DW-1:0] data_out,
  output logic          busy,
  output logic          pending,
  output logic          done,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                 ack_s;
  logic [DW-1:0]        buf_q, buf_d, data_d;
  logic                 req_d, pend_d, done_d, ovf_d;
  logic [7:0]           cnt_d;
  logic                 launch, drop;

  // Synchronize the asynchronous acknowledge; only the last stage is used.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign busy  = (state != IDLE);

  // Next-state, launch, event capture and drop accounting.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d = state;
    req_d   = req_out;
    data_d  = data_out;
    buf_d   = buf_q;
    pend_d  = pending;
    done_d  = 1'b0;
    ovf_d   = overflow;
    cnt_d   = drop_cnt;
    launch  = 1'b0;
    drop    = 1'b0;

    unique case (state)
      IDLE: begin
        // A stale acknowledge blocks the launch, so req never rises while ack_s=1.
        if (!ack_s && (pending || event_in)) begin
          launch  = 1'b1;
          state_d = REQ;
          req_d   = 1'b1;
          data_d  = pending ? buf_q : event_data;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A launch from the buffer frees the entry. A coincident event refills
    // the entry, so pending stays set. A launch straight from event_in
    // leaves the buffer alone.
    if (launch && pending) pend_d = event_in;
    if (event_in) begin
      if (launch) begin
        if (pending) buf_d = event_data;
      end else if (!pending) begin
        buf_d  = event_data;
        pend_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    // clr_drop is applied first, so a drop in the same cycle still registers.
    if (clr_drop) begin
      cnt_d = 8'd0;
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (cnt_d != 8'hFF) cnt_d = cnt_d + 8'd1;
    end
  end

  // State and registered outputs; reset aborts any transfer at once.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
      // NOTE: the buffer is cleared on reset as well, so no stale payload
      // from before the reset can ever reach data_out.
      buf_q    <= '0;
      pending  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      state    <= state_d;
      req_out  <= req_d;
      data_out <= data_d;
      buf_q    <= buf_d;
      pending  <= pend_d;
      done     <= done_d;
      overflow <= ovf_d;
      drop_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdc_event_sender.sv
// Bench for cdc_event_sender: directed scenarios plus a randomized phase.
// The reference model follows events: a transfer runs from launch until the
// synchronized ack has risen and fallen again. Waiting events sit in a queue
// that holds at most one entry. Each cycle, the outputs are compared with the
// model.
module tb_cdc_event_sender;
  localparam int DW = 8;
  localparam int SS = 4;

  logic          clka = 1'b0;
  logic          rst = 1'b1;
  logic          event_in = 1'b0;
  logic [DW-1:0] event_data = '0;
  logic          ack_in = 1'b0;
  logic          clr_drop = 1'b0;
  logic          req_out, busy, pending, done, overflow;
  logic [DW-1:0] data_out;
  logic [7:0]    drop_cnt;

  cdc_event_sender #(.DW(DW), .SYNC_STAGES(SS)) dut (
    .clka(clka), .rst(rst), .event_in(event_in), .event_data(event_data),
    .ack_in(ack_in), .clr_drop(clr_drop), .req_out(req_out),
    .data_out(data_out), .busy(busy), .pending(pending), .done(done),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clka = ~clka;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  bit prev_req = 1'b0;
  logic [7:0] rise_q[$];
  bit resp_en = 1'b0;
  int resp_wait = 0;
  int resp_lo = 3;
  int resp_hi = 3;

  // Reference model state.
  logic          m_busy = 1'b0, m_seen = 1'b0, m_req = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  logic [7:0]    m_data = '0, m_cnt = '0;
  logic [7:0]    m_pq[$];
  logic [SS-1:0] m_sync = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic       acks;
    logic       ev;
    logic       dropped;
    logic [7:0] ed;
    if (rst) begin
      m_busy = 0; m_seen = 0; m_req = 0; m_done = 0; m_ovf = 0;
      m_data = '0; m_cnt = '0; m_pq.delete(); m_sync = '0;
    end else begin
      acks    = m_sync[SS-1];
      ev      = event_in;
      ed      = event_data;
      dropped = 1'b0;
      m_done  = 1'b0;
      if (!m_busy) begin
        if (!acks && (m_pq.size() > 0 || ev)) begin
          if (m_pq.size() > 0) m_data = m_pq.pop_front();
          else begin m_data = ed; ev = 1'b0; end
          m_busy = 1; m_req = 1; m_seen = 0;
        end
      end else if (!m_seen) begin
        if (acks) begin m_seen = 1; m_req = 0; end
      end else if (!acks) begin
        m_busy = 0; m_done = 1;
      end
      if (ev) begin
        if (m_pq.size() == 0) m_pq.push_back(ed);
        else dropped = 1'b1;
      end
      if (clr_drop) begin m_cnt = 0; m_ovf = 0; end
      if (dropped) begin
        m_ovf = 1;
        if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
      end
      m_sync = {m_sync[SS-2:0], ack_in};
    end
  endtask

  initial begin
    forever begin
      @(posedge clka or posedge rst);
      model_step();
    end
  end

  // One cycle: compare against the model, track pulses and rises, and run
  // the destination responder.
  task automatic tick();
    @(negedge clka);
    if (!rst) begin
      check("req_out",  32'(req_out),  32'(m_req));
      check("busy",     32'(busy),     32'(m_busy));
      check("pending",  32'(pending),  32'(m_pq.size() != 0));
      check("done",     32'(done),     32'(m_done));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
      check("data_out", 32'(data_out), 32'(m_data));
    end
    if (done) n_done++;
    if (req_out && !prev_req) rise_q.push_back(data_out);
    prev_req = req_out;
    if (resp_en) begin
      if (req_out != ack_in) begin
        if (resp_wait == 0) ack_in = req_out;
        else resp_wait--;
      end else begin
        resp_wait = int'($urandom_range(resp_hi, resp_lo));
      end
    end
  endtask

  task automatic send(input logic [7:0] d);
    event_in = 1'b1;
    event_data = d;
    tick();
    event_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!busy && !pending && !req_out && !ack_in) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle"}, 32'(ok), 32'd1);
    repeat (SS + 2) tick();
  endtask

  task automatic check_rise(input string tag, input logic [7:0] exp);
    check({tag, "_present"}, 32'(rise_q.size() > 0), 32'd1);
    if (rise_q.size() > 0) check(tag, 32'(rise_q.pop_front()), 32'(exp));
  endtask

  initial begin
    int         base;
    bit         seen;
    logic [7:0] first_d;

    // Reset state while rst is held.
    #1;
    check("rst_req",      32'(req_out),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_pending",  32'(pending),  32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_data",     32'(data_out), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    resp_en = 1'b1;
    repeat (SS + 2) tick();

    // Single transfer.
    base = n_done;
    send(8'hA5);
    check("single_latency", 32'(req_out), 32'd1);
    check("single_data_now", 32'(data_out), 32'hA5);
    wait_idle("single");
    check("single_done_cnt", 32'(n_done - base), 32'd1);
    check_rise("single_data", 8'hA5);
    check("single_busy_end", 32'(busy), 32'd0);

    // Pending buffer.
    base = n_done;
    send(8'h11);
    tick();
    send(8'h22);
    check("pend_flag", 32'(pending), 32'd1);
    wait_idle("pend");
    check("pend_done_cnt", 32'(n_done - base), 32'd2);
    check_rise("pend_first", 8'h11);
    check_rise("pend_second", 8'h22);

    // Overflow: four back-to-back events.
    event_in = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      event_data = 8'(d);
      tick();
    end
    event_in = 1'b0;
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    check("ovf_flag",     32'(overflow), 32'd1);
    wait_idle("ovf");
    check_rise("ovf_first", 8'h01);
    check_rise("ovf_second", 8'h02);
    clr_drop = 1'b1;
    tick();
    clr_drop = 1'b0;
    check("ovf_clr_cnt",  32'(drop_cnt), 32'd0);
    check("ovf_clr_flag", 32'(overflow), 32'd0);

    // Saturation with ack held off, then clr_drop coinciding with a drop.
    resp_en = 1'b0;
    send(8'h70);
    event_in = 1'b1;
    first_d = 8'($urandom);
    event_data = first_d;
    tick();
    repeat (300) begin
      event_data = 8'($urandom);
      tick();
    end
    event_in = 1'b0;
    check("sat_cnt",  32'(drop_cnt), 32'd255);
    check("sat_flag", 32'(overflow), 32'd1);
    event_in = 1'b1;
    clr_drop = 1'b1;
    tick();
    event_in = 1'b0;
    clr_drop = 1'b0;
    check("simul_cnt",  32'(drop_cnt), 32'd1);
    check("simul_flag", 32'(overflow), 32'd1);
    resp_en = 1'b1;
    wait_idle("sat");
    check_rise("sat_first", 8'h70);
    check_rise("sat_second", first_d);
    clr_drop = 1'b1;
    tick();
    clr_drop = 1'b0;

    // Stale acknowledge blocks the launch.
    resp_en = 1'b0;
    ack_in = 1'b1;
    repeat (SS + 2) tick();
    send(8'h5A);
    repeat (6) tick();
    check("stale_req_low", 32'(req_out), 32'd0);
    check("stale_pending", 32'(pending), 32'd1);
    ack_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < SS + 4; i++) begin
      tick();
      if (req_out) begin
        seen = 1'b1;
        break;
      end
    end
    check("stale_launch", 32'(seen), 32'd1);
    resp_en = 1'b1;
    wait_idle("stale");
    check_rise("stale_data", 8'h5A);

    // Asynchronous reset in REQ with the buffer full and one drop counted.
    send(8'h33);
    tick();
    send(8'h44);
    send(8'h55);
    check("mid_pending", 32'(pending),  32'd1);
    check("mid_drop",    32'(drop_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req",     32'(req_out),  32'd0);
    check("arst_pending", 32'(pending),  32'd0);
    check("arst_busy",    32'(busy),     32'd0);
    check("arst_drop",    32'(drop_cnt), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    check_rise("arst_before", 8'h33);
    repeat (SS + 4) tick();
    send(8'h66);
    wait_idle("arst_after");
    check_rise("arst_next", 8'h66);

    // Randomized traffic with random acknowledge delays.
    resp_lo = 0;
    resp_hi = 6;
    repeat (600) begin
      event_in   = ($urandom_range(99) < 30);
      event_data = 8'($urandom);
      clr_drop   = ($urandom_range(99) < 3);
      tick();
    end
    event_in = 1'b0;
    clr_drop = 1'b0;
    wait_idle("random");
    rise_q.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
